// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-transaction SDRAM controller host port.
// One request is in flight at a time; a watchdog aborts transactions the controller never finishes.
module sdram_port_arbiter #(
  parameter int HADDR_WIDTH = 24,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [15:0]            p0_wdata,
  output logic                   p0_ack,
  output logic [15:0]            p0_rdata,
  output logic                   p0_rvalid,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [15:0]            p1_wdata,
  output logic                   p1_ack,
  output logic [15:0]            p1_rdata,
  output logic                   p1_rvalid,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  input  logic                   busy,
  output logic                   timeout_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

  logic [1:0]             state;
  logic                   last_grant;
  logic                   grant;
  logic                   win;
  logic                   l_we;
  logic                   aborted;
  logic [HADDR_WIDTH-1:0] l_addr;
  logic [15:0]            l_wdata;
  logic [7:0]             wdog;

  // A lone requester wins outright; a tie goes to the port not granted last.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) win = ~last_grant;
    else                  win = ~p0_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      l_we        <= 1'b0;
      aborted     <= 1'b0;
      l_addr      <= '0;
      l_wdata     <= '0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            grant      <= win;
            last_grant <= win;
            l_we       <= win ? p1_we    : p0_we;
            l_addr     <= win ? p1_addr  : p0_addr;
            l_wdata    <= win ? p1_wdata : p0_wdata;
            wdog       <= '0;
            aborted    <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE, S_ACTIVE: begin
          // Watchdog expiry wins over any completion seen in the same cycle.
          if (wdog == TO_CNT) begin
            state       <= S_DONE;
            aborted     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
            if (state == S_ISSUE) begin
              if (busy) state <= S_ACTIVE;
            end else if (l_we) begin
              if (!busy) state <= S_DONE;
            end else if (rd_ready) begin
              state <= S_DONE;
              if (grant) p1_rdata <= rd_data;
              else       p0_rdata <= rd_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wr_addr   = l_addr;
  assign rd_addr   = l_addr;
  assign wr_data   = l_wdata;
  assign wr_enable = (state == S_ISSUE) &&  l_we;
  assign rd_enable = (state == S_ISSUE) && !l_we;

  assign p0_ack    = (state == S_DONE) && !grant;
  assign p1_ack    = (state == S_DONE) &&  grant;
  assign p0_rvalid = p0_ack && !l_we && !aborted;
  assign p1_rvalid = p1_ack && !l_we && !aborted;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; the controller is played cycle by cycle from each task.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr, wr_addr, rd_addr;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, wr_data, rd_data;
  logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic        wr_enable, rd_enable, rd_ready, busy, timeout_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.HADDR_WIDTH(24), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy),
    .timeout_err(timeout_err)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    rd_data = '0; rd_ready = 0; busy = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst_n = 0;
    tick;
    tick;
    tests++;
    if ({p0_ack, p0_rvalid, p1_ack, p1_rvalid, wr_enable, rd_enable, timeout_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {p0_ack, p0_rvalid, p1_ack, p1_rvalid, wr_enable, rd_enable, timeout_err});
    end
    tests++;
    if ({p0_rdata, p1_rdata} !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h want 00000000", {p0_rdata, p1_rdata});
    end
    tests++;
    if ({wr_addr, wr_data} !== 40'h0) begin
      fails++;
      $display("FAIL reset_latch: got %h want 0", {wr_addr, wr_data});
    end
    rst_n = 1;
    tick;
  endtask

  task automatic test_write;
    p0_req = 1; p0_we = 1; p0_addr = 24'h012345; p0_wdata = 16'hBEEF;
    tick;
    tests++;
    if ({wr_enable, rd_enable, wr_addr, wr_data} !== {2'b10, 24'h012345, 16'hBEEF}) begin
      fails++;
      $display("FAIL wr_issue: got %b%b %h %h want 10 012345 beef", wr_enable, rd_enable, wr_addr, wr_data);
    end
    p0_req = 0;
    tick;
    tick;
    tests++;
    if (wr_enable !== 1'b1) begin
      fails++;
      $display("FAIL wr_hold: got %b want 1", wr_enable);
    end
    busy = 1;
    tick;
    tests++;
    if ({wr_enable, p0_ack} !== 2'b00) begin
      fails++;
      $display("FAIL wr_active: got %b want 00", {wr_enable, p0_ack});
    end
    tick;
    tick;
    busy = 0;
    tick;
    tests++;
    if ({p0_ack, p0_rvalid, p1_ack, wr_addr} !== {3'b100, 24'h012345}) begin
      fails++;
      $display("FAIL wr_ack: got %b %h want 100 012345", {p0_ack, p0_rvalid, p1_ack}, wr_addr);
    end
    tick;
    tests++;
    if (p0_ack !== 1'b0) begin
      fails++;
      $display("FAIL wr_ack_pulse: got %b want 0", p0_ack);
    end
  endtask

  task automatic test_tie_reads;
    do_reset;
    p0_req = 1; p0_we = 0; p0_addr = 24'h000100;
    p1_req = 1; p1_we = 0; p1_addr = 24'h000200;
    tick;
    tests++;
    if ({rd_enable, wr_enable, rd_addr} !== {2'b10, 24'h000100}) begin
      fails++;
      $display("FAIL tie_first: got %b %h want 10 000100", {rd_enable, wr_enable}, rd_addr);
    end
    busy = 1;
    tick;
    rd_data = 16'h1111; rd_ready = 1; busy = 0;
    tick;
    tests++;
    if ({p0_ack, p0_rvalid, p1_ack, p0_rdata} !== {3'b110, 16'h1111}) begin
      fails++;
      $display("FAIL tie_p0_done: got %b %h want 110 1111", {p0_ack, p0_rvalid, p1_ack}, p0_rdata);
    end
    rd_ready = 0; p0_req = 0;
    tick;
    tick;
    tests++;
    if ({rd_enable, rd_addr} !== {1'b1, 24'h000200}) begin
      fails++;
      $display("FAIL tie_second: got %b %h want 1 000200", rd_enable, rd_addr);
    end
    busy = 1;
    tick;
    rd_data = 16'hA5C3; rd_ready = 1; busy = 0;
    tick;
    tests++;
    if ({p1_ack, p1_rvalid, p0_ack, p1_rdata, p0_rdata} !== {3'b110, 16'hA5C3, 16'h1111}) begin
      fails++;
      $display("FAIL tie_p1_done: got %b %h %h want 110 a5c3 1111",
               {p1_ack, p1_rvalid, p0_ack}, p1_rdata, p0_rdata);
    end
    rd_ready = 0; p1_req = 0;
    tick;
    tests++;
    if ({p1_ack, p1_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL tie_p1_pulse: got %b want 00", {p1_ack, p1_rvalid});
    end
  endtask

  task automatic test_refresh;
    int bad;
    bad = 0;
    p0_req = 1; p0_we = 0; p0_addr = 24'h000777;
    tick;
    p0_req = 0;
    for (int i = 0; i < 12; i++) begin
      if (rd_enable !== 1'b1) bad++;
      tick;
    end
    tests++;
    if (bad != 0 || rd_enable !== 1'b1) begin
      fails++;
      $display("FAIL refresh_hold: got %0d low cycles want 0", bad);
    end
    busy = 1;
    tick;
    rd_data = 16'h1234; rd_ready = 1; busy = 0;
    tick;
    tests++;
    if ({p0_ack, p0_rvalid, timeout_err, p0_rdata} !== {3'b110, 16'h1234}) begin
      fails++;
      $display("FAIL refresh_done: got %b %h want 110 1234", {p0_ack, p0_rvalid, timeout_err}, p0_rdata);
    end
    rd_ready = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic e;
    do_reset;
    p0_req = 1; p0_we = 1; p0_wdata = 16'hA000; p0_addr = 24'h000001;
    p1_req = 1; p1_we = 1; p1_wdata = 16'hB001; p1_addr = 24'h000002;
    for (int t = 0; t < 4; t++) begin
      e = (t % 2) == 1;
      tick;
      tests++;
      if (wr_data !== (e ? 16'hB001 : 16'hA000)) begin
        fails++;
        $display("FAIL b2b_grant%0d: got %h want %h", t, wr_data, e ? 16'hB001 : 16'hA000);
      end
      busy = 1;
      tick;
      busy = 0;
      tick;
      tests++;
      if ({p1_ack, p0_ack} !== (e ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL b2b_ack%0d: got %b want %b", t, {p1_ack, p0_ack}, e ? 2'b10 : 2'b01);
      end
      tick;
      tests++;
      if ({p1_ack, p0_ack} !== 2'b00) begin
        fails++;
        $display("FAIL b2b_gap%0d: got %b want 00", t, {p1_ack, p0_ack});
      end
    end
    p0_req = 0; p1_req = 0;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    p1_req = 1; p1_we = 0; p1_addr = 24'h000003;
    tick;
    p1_req = 0;
    n = 0;
    while (n < 400 && p1_ack !== 1'b1) begin
      tick;
      n++;
    end
    tests++;
    if (p1_ack !== 1'b1 || n < 255 || n > 257) begin
      fails++;
      $display("FAIL to_ack: got ack=%b after %0d cycles want ack=1 after 255..257", p1_ack, n);
    end
    tests++;
    if ({p1_rvalid, timeout_err, p1_rdata} !== {2'b01, 16'h0000}) begin
      fails++;
      $display("FAIL to_flags: got %b %h want 01 0000", {p1_rvalid, timeout_err}, p1_rdata);
    end
    tick;
    tests++;
    if ({p1_ack, timeout_err} !== 2'b01) begin
      fails++;
      $display("FAIL to_sticky: got %b want 01", {p1_ack, timeout_err});
    end
    p0_req = 1; p0_we = 1; p0_addr = 24'h000004; p0_wdata = 16'h5555;
    tick;
    p0_req = 0; busy = 1;
    tick;
    busy = 0;
    tick;
    tests++;
    if ({p0_ack, timeout_err} !== 2'b11) begin
      fails++;
      $display("FAIL to_next: got %b want 11", {p0_ack, timeout_err});
    end
    tick;
  endtask

  task automatic test_reset_mid;
    p0_req = 1; p0_we = 0; p0_addr = 24'h00ABCD;
    tick;
    p0_req = 0; busy = 1;
    tick;
    tests++;
    if (rd_enable !== 1'b0) begin
      fails++;
      $display("FAIL mid_active: got %b want 0", rd_enable);
    end
    rst_n = 0;
    tick;
    rst_n = 1; busy = 0;
    tests++;
    if ({p0_ack, p1_ack, wr_enable, rd_enable, timeout_err} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset: got %b want 00000", {p0_ack, p1_ack, wr_enable, rd_enable, timeout_err});
    end
    tick;
    tests++;
    if ({p0_ack, p1_ack} !== 2'b00) begin
      fails++;
      $display("FAIL mid_noack: got %b want 00", {p0_ack, p1_ack});
    end
    p0_req = 1; p0_we = 0; p0_addr = 24'h000010;
    p1_req = 1; p1_we = 0; p1_addr = 24'h000020;
    tick;
    tests++;
    if ({rd_enable, rd_addr} !== {1'b1, 24'h000010}) begin
      fails++;
      $display("FAIL mid_tie: got %b %h want 1 000010", rd_enable, rd_addr);
    end
    idle_inputs;
    do_reset;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs;
    test_reset;
    test_write;
    test_tie_reads;
    test_refresh;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
